// File: rtl/icache_data_bank_ctrl.sv
// icache data-array controller: N-way banked line storage that arbitrates
// hit reads against linefill writes. It returns read data and forwarded
// linefill beats to upstream over a valid/ready channel with backpressure.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   rd_vld/rd_rdy              hit read request {rd_index,rd_way}, echoes rd_txnid
//   lf_vld/lf_rdy              linefill write of lf_data to {lf_index,lf_way}
//   lf_entry_idx, lf_fwd       owning MSHR entry; forward line upstream when set
//   entry_txnid, entry_merge   per-entry txnid table and merge matrix (row i, bit j)
//   v_linefill_done            per-entry completion pulse on the linefill accept cycle
//   up_vld/up_rdy, up_data, up_txnid   registered upstream data slot
module icache_data_bank_ctrl #(
  parameter int unsigned WAY_NUM     = 2,
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned LINE_WIDTH  = 512,
  parameter int unsigned BANK_NUM    = 2,
  parameter int unsigned TXNID_WIDTH = 8,
  parameter int unsigned ENTRY_NUM   = 8,
  localparam int unsigned WW = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
  localparam int unsigned EW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_vld,
  output logic                           rd_rdy,
  input  logic [WW-1:0]                  rd_way,
  input  logic [INDEX_WIDTH-1:0]         rd_index,
  input  logic [TXNID_WIDTH-1:0]         rd_txnid,
  input  logic                           lf_vld,
  output logic                           lf_rdy,
  input  logic [EW-1:0]                  lf_entry_idx,
  input  logic [WW-1:0]                  lf_way,
  input  logic [INDEX_WIDTH-1:0]         lf_index,
  input  logic [LINE_WIDTH-1:0]          lf_data,
  input  logic                           lf_fwd,
  input  logic [ENTRY_NUM*TXNID_WIDTH-1:0] entry_txnid,
  input  logic [ENTRY_NUM*ENTRY_NUM-1:0] entry_merge,
  output logic [ENTRY_NUM-1:0]           v_linefill_done,
  output logic                           up_vld,
  input  logic                           up_rdy,
  output logic [LINE_WIDTH-1:0]          up_data,
  output logic [TXNID_WIDTH-1:0]         up_txnid
);

  localparam int unsigned BW    = LINE_WIDTH / BANK_NUM;
  localparam int unsigned AW    = INDEX_WIDTH + WW;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [0:0] {IDLE, FANOUT} state_t;

  state_t                  state_q, state_d;
  logic [ENTRY_NUM-1:0]    fanout_q, fanout_d;
  logic [LINE_WIDTH-1:0]   cap_q, cap_d;
  logic                    rd_pipe_vld_q, rd_pipe_vld_d;
  logic                    up_vld_d;
  logic [LINE_WIDTH-1:0]   up_data_d;
  logic [TXNID_WIDTH-1:0]  up_txnid_d;

  logic [BW-1:0]           mem [BANK_NUM][DEPTH];

  logic                    slot_free_c, lf_acc_c, rd_acc_c, found_c;
  logic [ENTRY_NUM-1:0]    pulse_c;
  logic [LINE_WIDTH-1:0]   rd_line_c;
  logic [AW-1:0]           rd_addr_c, lf_addr_c;

  // Handshake arbitration: a linefill write always wins over a same-cycle read
  assign slot_free_c = !up_vld || up_rdy;
  assign lf_rdy      = (state_q == IDLE) && !rd_pipe_vld_q;
  assign lf_acc_c    = lf_vld && lf_rdy;
  assign rd_rdy      = (state_q == IDLE) && !lf_acc_c && !rd_pipe_vld_q && slot_free_c;
  assign rd_acc_c    = rd_vld && rd_rdy;
  assign rd_addr_c   = {rd_index, rd_way};
  assign lf_addr_c   = {lf_index, lf_way};

  // Owning entry plus every entry merged onto its line
  always_comb begin
    pulse_c = '0;
    for (int i = 0; i < int'(ENTRY_NUM); i++) begin
      pulse_c[i] = (EW'(i) == lf_entry_idx) || entry_merge[i*int'(ENTRY_NUM) + int'(lf_entry_idx)];
    end
  end

  assign v_linefill_done = lf_acc_c ? pulse_c : '0;

  // Bank read; the result is captured straight into the out slot on accept
  always_comb begin
    rd_line_c = '0;
    for (int b = 0; b < int'(BANK_NUM); b++) begin
      rd_line_c[b*int'(BW) +: BW] = mem[b][rd_addr_c];
    end
  end

  // Line storage: all banks written together on linefill accept
  always_ff @(posedge clk) begin
    if (lf_acc_c) begin
      for (int b = 0; b < int'(BANK_NUM); b++) begin
        mem[b][lf_addr_c] <= lf_data[b*int'(BW) +: BW];
      end
    end
  end

  // Next-state and out-slot logic
  always_comb begin
    state_d       = state_q;
    fanout_d      = fanout_q;
    cap_d         = cap_q;
    rd_pipe_vld_d = rd_acc_c;
    up_vld_d      = up_vld && !up_rdy;
    up_data_d     = up_data;
    up_txnid_d    = up_txnid;
    found_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (lf_acc_c && lf_fwd) begin
          state_d  = FANOUT;
          fanout_d = pulse_c;
          cap_d    = lf_data;
        end else if (rd_acc_c) begin
          up_vld_d   = 1'b1;
          up_data_d  = rd_line_c;
          up_txnid_d = rd_txnid;
        end
      end
      FANOUT: begin
        if (slot_free_c) begin
          if (fanout_q == '0) begin
            state_d = IDLE;
          end else begin
            // Issue the lowest pending entry
            for (int k = 0; k < int'(ENTRY_NUM); k++) begin
              if (!found_c && fanout_q[k]) begin
                found_c     = 1'b1;
                up_vld_d    = 1'b1;
                up_data_d   = cap_q;
                up_txnid_d  = entry_txnid[k*int'(TXNID_WIDTH) +: TXNID_WIDTH];
                fanout_d[k] = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and out-slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fanout_q      <= '0;
      cap_q         <= '0;
      rd_pipe_vld_q <= 1'b0;
      up_vld        <= 1'b0;
      up_data       <= '0;
      up_txnid      <= '0;
    end else begin
      state_q       <= state_d;
      fanout_q      <= fanout_d;
      cap_q         <= cap_d;
      rd_pipe_vld_q <= rd_pipe_vld_d;
      up_vld        <= up_vld_d;
      up_data       <= up_data_d;
      up_txnid      <= up_txnid_d;
    end
  end

endmodule

// File: tb/tb_icache_data_bank_ctrl.sv
// Self-checking bench for icache_data_bank_ctrl: a transaction-level model
// (line memory + expected-beat queue) checked every cycle, plus directed
// literal checks. A second 4-way/4-bank instance covers bank and way slicing.
module tb_icache_data_bank_ctrl;

  localparam int unsigned LW = 512;
  localparam int unsigned TW = 8;
  localparam int unsigned EN = 8;
  localparam int unsigned IW = 6;
  localparam int unsigned QLW = 128;

  typedef struct {
    logic [TW-1:0] txnid;
    logic [LW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rd_vld, rd_rdy, lf_vld, lf_rdy, lf_fwd, up_vld, up_rdy;
  logic [0:0]    rd_way, lf_way;
  logic [IW-1:0] rd_index, lf_index;
  logic [TW-1:0] rd_txnid, up_txnid;
  logic [2:0]    lf_entry_idx;
  logic [LW-1:0] lf_data, up_data;
  logic [EN*TW-1:0] entry_txnid;
  logic [EN*EN-1:0] entry_merge;
  logic [EN-1:0] v_linefill_done;

  icache_data_bank_ctrl #(
    .WAY_NUM(2), .INDEX_WIDTH(IW), .LINE_WIDTH(LW), .BANK_NUM(2), .TXNID_WIDTH(TW), .ENTRY_NUM(EN)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_way(rd_way), .rd_index(rd_index), .rd_txnid(rd_txnid),
    .lf_vld(lf_vld), .lf_rdy(lf_rdy), .lf_entry_idx(lf_entry_idx), .lf_way(lf_way),
    .lf_index(lf_index), .lf_data(lf_data), .lf_fwd(lf_fwd),
    .entry_txnid(entry_txnid), .entry_merge(entry_merge), .v_linefill_done(v_linefill_done),
    .up_vld(up_vld), .up_rdy(up_rdy), .up_data(up_data), .up_txnid(up_txnid)
  );

  // 4-way, 4-bank instance
  logic           q_rd_vld, q_rd_rdy, q_lf_vld, q_lf_rdy, q_up_vld;
  logic [1:0]     q_rd_way, q_lf_way;
  logic [2:0]     q_rd_index, q_lf_index;
  logic [TW-1:0]  q_up_txnid;
  logic [QLW-1:0] q_lf_data, q_up_data;
  logic [EN-1:0]  q_done;
  logic [EN*TW-1:0] q_entry_txnid = '0;
  logic [EN*EN-1:0] q_entry_merge = '0;
  logic [2:0]     q_entry_idx = '0;
  logic           q_up_rdy = 1'b1;
  logic           q_lf_fwd = 1'b0;
  logic [TW-1:0]  q_rd_txnid = 8'h77;

  icache_data_bank_ctrl #(
    .WAY_NUM(4), .INDEX_WIDTH(3), .LINE_WIDTH(QLW), .BANK_NUM(4), .TXNID_WIDTH(TW), .ENTRY_NUM(EN)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .rd_vld(q_rd_vld), .rd_rdy(q_rd_rdy), .rd_way(q_rd_way), .rd_index(q_rd_index), .rd_txnid(q_rd_txnid),
    .lf_vld(q_lf_vld), .lf_rdy(q_lf_rdy), .lf_entry_idx(q_entry_idx), .lf_way(q_lf_way),
    .lf_index(q_lf_index), .lf_data(q_lf_data), .lf_fwd(q_lf_fwd),
    .entry_txnid(q_entry_txnid), .entry_merge(q_entry_merge), .v_linefill_done(q_done),
    .up_vld(q_up_vld), .up_rdy(q_up_rdy), .up_data(q_up_data), .up_txnid(q_up_txnid)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  // ---------------- model ----------------
  logic [LW-1:0] mdl_mem [int];
  beat_t         exp_q [$];
  logic [TW-1:0] seen_q [$];
  logic [EN-1:0] last_pulse;
  logic          rd_acc_prev, prev_stall;
  logic [LW-1:0] prev_data;
  logic [TW-1:0] prev_txnid;

  // Entries finished by a fill of entry idx: idx itself and every entry whose row marks idx
  function automatic logic [EN-1:0] exp_pulse(input int idx);
    logic [EN-1:0] e;
    e = '0;
    for (int i = 0; i < int'(EN); i++) e[i] = (i == idx) || entry_merge[i*EN + idx];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("reset_up_vld", LW'(up_vld), '0);
      rd_acc_prev = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_stable", {up_vld, up_txnid, up_data[LW-10:0]}, {1'b1, prev_txnid, prev_data[LW-10:0]});
      if (rd_acc_prev) chk("rd_latency", LW'(up_vld), LW'(1));
      if (up_vld && up_rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", LW'(up_txnid), '1);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_txnid", LW'(up_txnid), LW'(b.txnid));
          chk("beat_data", up_data, b.data);
          seen_q.push_back(up_txnid);
        end
      end
      if (lf_vld && lf_rdy) begin
        logic [EN-1:0] p;
        p = exp_pulse(int'(lf_entry_idx));
        last_pulse = v_linefill_done;
        chk("lf_pulse", LW'(v_linefill_done), LW'(p));
        mdl_mem[int'({lf_index, lf_way})] = lf_data;
        if (lf_fwd)
          for (int i = 0; i < int'(EN); i++)
            if (p[i]) exp_q.push_back('{entry_txnid[i*TW +: TW], lf_data});
        if (rd_vld) chk("rd_blocked_by_lf", LW'(rd_rdy), '0);
      end else begin
        chk("no_pulse", LW'(v_linefill_done), '0);
      end
      if (rd_vld && rd_rdy) begin
        chk("rd_only_when_drained", LW'(exp_q.size()), '0);
        exp_q.push_back('{rd_txnid, mdl_mem[int'({rd_index, rd_way})]});
      end
      rd_acc_prev = rd_vld && rd_rdy;
      prev_stall  = up_vld && !up_rdy;
      prev_data   = up_data;
      prev_txnid  = up_txnid;
    end
  end

  // ---------------- drivers ----------------
  task automatic do_lf(input logic [2:0] idx, input logic [IW-1:0] index, input logic way,
                       input logic [LW-1:0] data, input logic fwd);
    bit ok;
    ok = 0;
    lf_entry_idx = idx; lf_index = index; lf_way = way; lf_data = data; lf_fwd = fwd; lf_vld = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (lf_rdy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) timeout("lf_accept");
    @(posedge clk); #1;
    lf_vld = 1'b0;
  endtask

  task automatic do_rd(input logic [IW-1:0] index, input logic way, input logic [TW-1:0] txnid);
    bit ok;
    ok = 0;
    rd_index = index; rd_way = way; rd_txnid = txnid; rd_vld = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd_rdy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) timeout("rd_accept");
    @(posedge clk); #1;
    rd_vld = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !up_vld) begin ok = 1; break; end
    end
    if (!ok) timeout("drain");
    @(posedge clk); #1;
  endtask

  task automatic q_lf(input logic [1:0] way, input logic [QLW-1:0] data);
    bit ok;
    ok = 0;
    q_lf_index = 3'd2; q_lf_way = way; q_lf_data = data; q_lf_vld = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q_lf_rdy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) timeout("q_lf_accept");
    @(posedge clk); #1;
    q_lf_vld = 1'b0;
  endtask

  task automatic q_rd_chk(input logic [1:0] way, input logic [QLW-1:0] exp);
    bit ok;
    ok = 0;
    q_rd_index = 3'd2; q_rd_way = way; q_rd_vld = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q_rd_rdy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) timeout("q_rd_accept");
    @(posedge clk); #1;
    q_rd_vld = 1'b0;
    @(negedge clk);
    chk($sformatf("q_vld_w%0d", way), LW'(q_up_vld), LW'(1));
    for (int b = 0; b < 4; b++)
      chk($sformatf("q_w%0d_bank%0d", way, b), LW'(q_up_data[b*32 +: 32]), LW'(exp[b*32 +: 32]));
  endtask

  function automatic logic [QLW-1:0] q_line(input int way, input logic [15:0] hi);
    logic [QLW-1:0] l;
    for (int b = 0; b < 4; b++) l[b*32 +: 32] = {hi, 8'h00, 4'(way), 4'(b)};
    return l;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [LW-1:0] line_a5, line_b, line_c, line_d, line_e, line_f, line_g;
    bit found;
    line_a5 = {16{32'hA5A5_A5A5}};
    line_b  = {16{32'h1234_5678}};
    line_c  = {8{64'hCAFE_0000_BEEF_0001}};
    line_d  = {16{32'h0D0D_0D0D}};
    line_e  = {16{32'h9999_1111}};
    line_f  = {16{32'h5A5A_F00F}};
    line_g  = {16{32'h7777_0123}};
    rd_vld = 0; lf_vld = 0; up_rdy = 1; lf_fwd = 0; lf_data = '0; lf_index = '0; lf_way = '0;
    lf_entry_idx = '0; rd_index = '0; rd_way = '0; rd_txnid = '0;
    q_rd_vld = 0; q_lf_vld = 0; q_rd_way = '0; q_rd_index = '0; q_lf_way = '0; q_lf_index = '0; q_lf_data = '0;
    for (int i = 0; i < int'(EN); i++) entry_txnid[i*TW +: TW] = 8'hE0 + 8'(i);
    entry_merge = '0;
    entry_merge[5*EN + 2] = 1'b1;
    entry_merge[7*EN + 2] = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_up_vld", LW'(up_vld), '0);
    chk("rst_up_data", up_data, '0);
    chk("rst_up_txnid", LW'(up_txnid), '0);
    chk("rst_lf_rdy", LW'(lf_rdy), LW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // array-only fill then read of idx 3 / way 1
    do_lf(3'd0, 6'd3, 1'b1, line_a5, 1'b0);
    do_rd(6'd3, 1'b1, 8'h3C);
    @(negedge clk);
    chk("rd1_vld", LW'(up_vld), LW'(1));
    chk("rd1_data", up_data, line_a5);
    chk("rd1_txnid", LW'(up_txnid), LW'(8'h3C));
    drain();

    // forwarded fill, entry 2 with entries 5 and 7 merged
    seen_q.delete();
    do_lf(3'd2, 6'd7, 1'b0, line_b, 1'b1);
    drain();
    chk("fan_pulse", LW'(last_pulse), LW'(8'b1010_0100));
    chk("fan_nbeats", LW'(seen_q.size()), LW'(3));
    chk("fan_order", {seen_q[0], seen_q[1], seen_q[2]}, LW'({8'hE2, 8'hE5, 8'hE7}));

    // same with upstream backpressure
    seen_q.delete();
    do_lf(3'd2, 6'd8, 1'b1, line_c, 1'b1);
    up_rdy = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_beat", {up_vld, up_txnid}, LW'({1'b1, 8'hE2}));
    @(posedge clk); #1;
    up_rdy = 1'b1;
    drain();
    chk("stall_nbeats", LW'(seen_q.size()), LW'(3));
    chk("stall_order", {seen_q[0], seen_q[1], seen_q[2]}, LW'({8'hE2, 8'hE5, 8'hE7}));

    // read and linefill in the same cycle: write wins, read follows the fanout
    seen_q.delete();
    rd_index = 6'd3; rd_way = 1'b1; rd_txnid = 8'h55; rd_vld = 1'b1;
    lf_entry_idx = 3'd1; lf_index = 6'd20; lf_way = 1'b0; lf_data = line_d; lf_fwd = 1'b1; lf_vld = 1'b1;
    @(negedge clk);
    chk("coll_rd_rdy", LW'(rd_rdy), '0);
    chk("coll_lf_rdy", LW'(lf_rdy), LW'(1));
    @(posedge clk); #1;
    lf_vld = 1'b0;
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rd_rdy) begin found = 1; break; end
      @(posedge clk); #1;
    end
    if (!found) timeout("coll_rd_accept");
    @(posedge clk); #1;
    rd_vld = 1'b0;
    drain();
    chk("coll_order", {seen_q[0], seen_q[1]}, LW'({8'hE1, 8'h55}));

    // array-only fill then read of the same line returns the new data
    do_lf(3'd4, 6'd10, 1'b0, line_e, 1'b0);
    do_rd(6'd10, 1'b0, 8'h66);
    @(negedge clk);
    chk("raw_data", up_data, line_e);
    drain();

    // reset during the second fanout beat
    do_lf(3'd2, 6'd12, 1'b0, line_f, 1'b1);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (up_vld && up_txnid == 8'hE5) begin found = 1; break; end
    end
    if (!found) timeout("beat2_wait");
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_up_vld", LW'(up_vld), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", {lf_rdy, up_vld}, LW'(2'b10));

    // recovery: forwarded fill and read after reset
    do_lf(3'd3, 6'd33, 1'b1, line_g, 1'b1);
    do_rd(6'd33, 1'b1, 8'h21);
    drain();

    // 4-way / 4-bank instance
    for (int w = 0; w < 4; w++) q_lf(2'(w), q_line(w, 16'hC0DE));
    q_lf(2'd3, q_line(3, 16'hFEED));
    q_rd_chk(2'd3, {32'hFEED_0033, 32'hFEED_0032, 32'hFEED_0031, 32'hFEED_0030});
    for (int w = 0; w < 3; w++) q_rd_chk(2'(w), q_line(w, 16'hC0DE));

    chk("queue_empty", LW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
